log_lane_engine: RTL

Multi-lane obstacle/log scroller for the Frogger playfield. It generalises the single-log mover to `NUM_LANES` lanes with `LOGS_PER_LANE` slots each. Each lane has its own speed and direction, and a pseudo-random spawn timer. One lane is updated per clock, sequenced by `frame_tick`; the renderer and collision logic read the packed position/active vectors.

---
 rtl/log_lane_engine.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/log_lane_engine.sv
// log_lane_engine
//   Multi-lane log scroller for the Frogger playfield. Each frame_tick starts a
//   pass that updates one lane per clock: active logs move by the lane speed in
//   the lane direction, logs past the far edge are retired, and a per-lane
//   spawn timer (reloaded with LFSR jitter) brings new logs in at the entry edge.
//
// Ports
//   clk, reset   : system clock, synchronous active-high reset
//   frame_tick   : one-cycle pulse per frame, starts a pass when run is high
//   run          : low freezes all state and ignores frame_tick
//   speed_cfg    : 3-bit px/frame per lane, lane k at [3k+2:3k]
//   dir_cfg      : per lane, 1 = right, 0 = left
//   log_pos      : offset x per slot (screen x = log_pos - LOG_W), X_W bits each
//   log_active   : slot valid flags, index lane*LOGS_PER_LANE + slot
//   busy         : pass in progress
//   update_done  : one-cycle pulse at the end of a pass
//   overrun      : one-cycle pulse when a frame_tick lands while busy
module log_lane_engine #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned LOGS_PER_LANE = 2,
    parameter int unsigned SCREEN_W      = 320,
    parameter int unsigned LOG_W         = 96,
    parameter int unsigned X_W           = 10,
    parameter int unsigned GAP_MIN       = 24,
    parameter int unsigned GAP_BITS      = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  frame_tick,
    input  logic                                  run,
    input  logic [NUM_LANES*3-1:0]                speed_cfg,
    input  logic [NUM_LANES-1:0]                  dir_cfg,
    output logic [NUM_LANES*LOGS_PER_LANE*X_W-1:0] log_pos,
    output logic [NUM_LANES*LOGS_PER_LANE-1:0]    log_active,
    output logic                                  busy,
    output logic                                  update_done,
    output logic                                  overrun
);

    localparam int unsigned NumSlots = NUM_LANES * LOGS_PER_LANE;
    localparam int unsigned Span     = SCREEN_W + LOG_W;
    localparam int unsigned LaneW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned TimerW   = $clog2(GAP_MIN + (1 << GAP_BITS));

    localparam logic [X_W:0]   SpanExt   = (X_W+1)'(Span);
    localparam logic [X_W-1:0] EntryLeft = X_W'(Span);
    localparam logic [7:0]     LfsrSeed  = 8'hA5;
    // Galois taps for x^8+x^6+x^5+x^4+1 in right-shift form
    localparam logic [7:0]     LfsrTaps  = 8'hB8;

    typedef enum logic {StIdle, StUpdate} state_e;

    state_e                 state_q, state_d;
    logic [LaneW-1:0]       lane_q, lane_d;
    logic [X_W-1:0]         pos_q [NumSlots];
    logic [X_W-1:0]         pos_d [NumSlots];
    logic [NumSlots-1:0]    active_q, active_d;
    logic [TimerW-1:0]      timer_q [NUM_LANES];
    logic [TimerW-1:0]      timer_d [NUM_LANES];
    logic [7:0]             lfsr_q, lfsr_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    // Per-pass scratch for the lane being processed
    logic [2:0]             speed;
    logic                   dir_right;
    logic [TimerW-1:0]      timer_cur, timer_nxt;
    logic [NumSlots-1:0]    free_sel;
    logic                   spawn;
    logic [X_W:0]           spd_ext, pos_ext, sum;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        pos_d     = pos_q;
        active_d  = active_q;
        timer_d   = timer_q;
        lfsr_d    = lfsr_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        speed     = '0;
        dir_right = 1'b0;
        timer_cur = '0;
        timer_nxt = '0;
        free_sel  = '0;
        spawn     = 1'b0;
        spd_ext   = '0;
        pos_ext   = '0;
        sum       = '0;

        unique case (state_q)
            StIdle: begin
                if (frame_tick && run) begin
                    state_d = StUpdate;
                    lane_d  = '0;
                end
            end
            StUpdate: begin
                overrun_d = frame_tick && run;
                if (run) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (LaneW'(k) == lane_q) begin
                            speed     = speed_cfg[3*k +: 3];
                            dir_right = dir_cfg[k];
                            timer_cur = timer_q[k];
                        end
                    end
                    spd_ext = {{(X_W-2){1'b0}}, speed};

                    // Descending scan leaves the lowest-index free slot selected;
                    // uses pre-pass flags so a slot retired now is not reused now.
                    for (int i = NumSlots - 1; i >= 0; i--) begin
                        if (LaneW'(i / LOGS_PER_LANE) == lane_q && !active_q[i]) begin
                            free_sel    = '0;
                            free_sel[i] = 1'b1;
                        end
                    end

                    // Speed 0 freezes the lane entirely, including the timer.
                    timer_nxt = timer_cur;
                    if (speed != '0) begin
                        if (timer_cur != '0) begin
                            timer_nxt = timer_cur - TimerW'(1);
                        end else if (free_sel != '0) begin
                            spawn     = 1'b1;
                            timer_nxt = TimerW'(GAP_MIN) + TimerW'(lfsr_q[GAP_BITS-1:0]);
                        end
                    end

                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (LaneW'(k) == lane_q) begin
                            timer_d[k] = timer_nxt;
                        end
                    end

                    for (int i = 0; i < NumSlots; i++) begin
                        if (LaneW'(i / LOGS_PER_LANE) == lane_q) begin
                            pos_ext = {1'b0, pos_q[i]};
                            sum     = pos_ext + spd_ext;
                            if (active_q[i] && speed != '0) begin
                                if (dir_right) begin
                                    if (sum >= SpanExt) begin
                                        active_d[i] = 1'b0;
                                    end else begin
                                        pos_d[i] = sum[X_W-1:0];
                                    end
                                end else begin
                                    if (pos_ext <= spd_ext) begin
                                        active_d[i] = 1'b0;
                                    end else begin
                                        pos_d[i] = pos_q[i] - spd_ext[X_W-1:0];
                                    end
                                end
                            end
                            if (spawn && free_sel[i]) begin
                                active_d[i] = 1'b1;
                                pos_d[i]    = dir_right ? '0 : EntryLeft;
                            end
                        end
                    end

                    lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LfsrTaps : 8'h00);

                    if (lane_q == LaneW'(NUM_LANES - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        lane_d = lane_q + LaneW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            lane_q    <= '0;
            active_q  <= '0;
            lfsr_q    <= LfsrSeed;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NumSlots; i++) begin
                pos_q[i] <= '0;
            end
            for (int k = 0; k < NUM_LANES; k++) begin
                timer_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            active_q  <= active_d;
            lfsr_q    <= lfsr_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            pos_q     <= pos_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        log_pos = '0;
        for (int i = 0; i < NumSlots; i++) begin
            log_pos[i*X_W +: X_W] = pos_q[i];
        end
    end

    assign log_active  = active_q;
    assign busy        = (state_q == StUpdate);
    assign update_done = done_q;
    assign overrun     = overrun_q;

endmodule
